// File: rtl/spi_master_tx_pkg.sv
// ---------------------------------------------------------------------------
// spi_master_tx_pkg
//   Definitions shared by the SPI transmitter and its clock divider:
//   FSM state encodings, the default frame geometry and the width of the
//   sclk half-period divider counter.
// ---------------------------------------------------------------------------
package spi_master_tx_pkg;

    // FSM encodings. The receiver side decodes the same values.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam int SPI_DATA_W       = 8;
    localparam int SPI_FRAME_PULSES = SPI_DATA_W + 1;

    // The divider must hold CLK_DIV-1 for CLK_DIV up to 255.
    localparam int DIV_CNT_W = 8;

    // Pulse counter runs 0..data_w+1 and never wraps.
    function automatic int pulse_cnt_w(input int data_w);
        return $clog2(data_w + 2);
    endfunction

endpackage

// File: rtl/spi_master_tx_if.sv
// ---------------------------------------------------------------------------
// spi_master_tx_if
//   Byte handshake into the SPI transmitter.
//   in_valid : producer has a byte on data_in
//   in_ready : transmitter idle; the byte is taken on valid & ready
//   data_in  : byte to send
//   modports : master (producer side), slave (transmitter side)
// ---------------------------------------------------------------------------
interface spi_master_tx_if
    import spi_master_tx_pkg::*;
#(
    parameter int DATA_W = SPI_DATA_W
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] data_in;

    modport master (output in_valid, output data_in, input in_ready);
    modport slave  (input in_valid, input data_in, output in_ready);
endinterface

// File: rtl/spi_master_tx_clk_div.sv
// ---------------------------------------------------------------------------
// spi_clk_div
//   Counts 0..CLK_DIV-1 while enabled and emits a one-cycle tick at the
//   terminal count; the transmitter toggles sclk on every tick.
//   i_clk/i_rst : system clock, async active-high reset
//   i_en        : count enable
//   i_clr       : synchronous clear, wins over enable
//   o_tick      : terminal count reached this cycle
// ---------------------------------------------------------------------------
module spi_clk_div
    import spi_master_tx_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    input  logic i_clr,
    output logic o_tick
);
    logic [DIV_CNT_W-1:0] r_cnt;
    logic                 w_term;

    assign w_term = (r_cnt == DIV_CNT_W'(CLK_DIV - 1));
    assign o_tick = i_en & w_term;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= w_term ? '0 : r_cnt + DIV_CNT_W'(1);
        end
    end
endmodule

// File: rtl/spi_master_tx.sv
// ---------------------------------------------------------------------------
// spi_master_tx
//   Byte-wide SPI transmitter. A byte taken on the handshake is sent as
//   DATA_W data pulses plus one framing pulse (mosi=0) on a self-generated
//   sclk; the downstream slave counts pulses instead of using a chip select.
//   i_clk/i_rst : system clock, async active-high reset
//   bus         : spi_master_tx_if.slave (in_valid / in_ready / data_in)
//   o_busy      : frame in progress
//   o_done      : one-cycle pulse after the last sclk falling edge
//   o_sclk      : SPI clock, idles low
//   o_mosi      : SPI data, idles low, changes only with sclk falling/accept
// ---------------------------------------------------------------------------
module spi_master_tx
    import spi_master_tx_pkg::*;
#(
    parameter int CLK_DIV   = 4,
    parameter int DATA_W    = SPI_DATA_W,
    parameter int LSB_FIRST = 0
) (
    input  logic           i_clk,
    input  logic           i_rst,
    spi_master_tx_if.slave bus,
    output logic           o_busy,
    output logic           o_done,
    output logic           o_sclk,
    output logic           o_mosi
);
    localparam int               PCNT_W     = pulse_cnt_w(DATA_W);
    localparam logic [PCNT_W-1:0] LAST_PULSE = PCNT_W'(DATA_W + 1);
    localparam bit               LSBF       = (LSB_FIRST != 0);

    logic [1:0]        r_state;
    logic [DATA_W-1:0] r_shreg;
    logic [PCNT_W-1:0] r_pcnt;
    logic              r_sclk;
    logic              r_mosi;

    logic              w_shift;
    logic              w_tick;
    logic              w_rise;
    logic              w_fall;
    logic [DATA_W-1:0] w_shifted;

    // Bit that goes on the wire next: the end of the register facing out.
    function automatic logic lead_bit(input logic [DATA_W-1:0] v);
        return LSBF ? v[0] : v[DATA_W-1];
    endfunction

    assign w_shift      = (r_state == ST_SHIFT);
    assign bus.in_ready = (r_state == ST_IDLE);
    assign o_busy       = w_shift;
    assign o_done       = (r_state == ST_DONE);
    assign o_sclk       = r_sclk;
    assign o_mosi       = r_mosi;

    // Divider held in clear outside SHIFT, so every frame starts from zero
    // and the first rise lands exactly CLK_DIV cycles after accept.
    spi_clk_div #(.CLK_DIV(CLK_DIV)) u_div (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_en   (w_shift),
        .i_clr  (~w_shift),
        .o_tick (w_tick)
    );

    assign w_rise = w_tick & ~r_sclk;
    assign w_fall = w_tick &  r_sclk;

    // Zeros shift in behind the data, so after DATA_W shifts the lead bit
    // is already 0 for the framing pulse.
    assign w_shifted = LSBF ? (r_shreg >> 1) : (r_shreg << 1);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_shreg <= '0;
            r_pcnt  <= '0;
            r_sclk  <= 1'b0;
            r_mosi  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        r_shreg <= bus.data_in;
                        r_mosi  <= lead_bit(bus.data_in);
                        r_pcnt  <= '0;
                        r_state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (w_tick) r_sclk <= ~r_sclk;
                    if (w_rise) r_pcnt <= r_pcnt + PCNT_W'(1);
                    if (w_fall) begin
                        if (r_pcnt == LAST_PULSE) begin
                            r_mosi  <= 1'b0;
                            r_state <= ST_DONE;
                        end else begin
                            r_shreg <= w_shifted;
                            r_mosi  <= lead_bit(w_shifted);
                        end
                    end
                end
                ST_DONE: begin
                    r_pcnt  <= '0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_sclk  <= 1'b0;
                    r_mosi  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_spi_master_tx.sv
// ---------------------------------------------------------------------------
// tb_spi_master_tx
//   Four transmitters side by side (CLK_DIV/LSB_FIRST = 2/1, 2/0, 1/0, 5/0).
//   The reference gives every output as a closed-form function of the number
//   of clock edges since the byte was accepted; a pulse-counting slave
//   rebuilds each byte from mosi sampled on sclk rises.
// ---------------------------------------------------------------------------
module tb_spi_master_tx;
    localparam int N = 4;
    localparam int W = 8;

    function automatic int div_of(input int g);
        case (g)
            0: return 2;
            1: return 2;
            2: return 1;
            default: return 5;
        endcase
    endfunction

    function automatic int lsb_of(input int g);
        return (g == 0) ? 1 : 0;
    endfunction

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] valid_v = '0;
    logic [W-1:0] data_a [N];
    logic [N-1:0] rdy_v, busy_v, done_v, sclk_v, mosi_v;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        spi_master_tx_if #(.DATA_W(W)) bus ();
        assign bus.in_valid = valid_v[g];
        assign bus.data_in  = data_a[g];
        assign rdy_v[g]     = bus.in_ready;
        spi_master_tx #(.CLK_DIV(div_of(g)), .DATA_W(W), .LSB_FIRST(lsb_of(g))) u_dut (
            .i_clk  (clk),
            .i_rst  (rst),
            .bus    (bus),
            .o_busy (busy_v[g]),
            .o_done (done_v[g]),
            .o_sclk (sclk_v[g]),
            .o_mosi (mosi_v[g])
        );
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input int g, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %0h, expected %0h (t=%0t)", name, g, act, exp, $time);
        end
    endtask

    // Expected {in_ready, busy, done, sclk, mosi}, k edges after accept (-1 = idle).
    function automatic logic [4:0] exp_out(input int k, input int d, input int lsbf, input logic [W-1:0] b);
        int   f, p;
        logic m;
        f = 2 * d * (W + 1);
        if (k < 0) return 5'b10000;
        if (k == f) return 5'b00100;
        p = k / (2 * d);
        m = 1'b0;
        if (p < W) m = (lsbf != 0) ? b[p] : b[W-1-p];
        return {1'b0, 1'b1, 1'b0, ((k / d) % 2) != 0, m};
    endfunction

    // Reference and monitor state
    int           k [N];
    logic [W-1:0] mbyte [N];
    logic [W-1:0] pd [N];
    logic [N-1:0] pv = '0, pa = '0, psclk = '0;
    int           cyc = 0;
    int           rise_cnt [N], acc_cyc [N], fall_cyc [N], done_cyc [N];
    int           first_gap [N], lat [N], done_cnt [N];
    logic [8:0]   cap [N];
    logic [W-1:0] sbyte [N];

    initial begin
        for (int g = 0; g < N; g++) begin
            k[g] = -1; mbyte[g] = '0; pd[g] = '0; rise_cnt[g] = 0; acc_cyc[g] = 0;
            fall_cyc[g] = 0; done_cyc[g] = 0; first_gap[g] = 0; lat[g] = 0;
            done_cnt[g] = 0; cap[g] = '0; sbyte[g] = '0;
        end
        forever begin
            @(negedge clk);
            cyc++;
            for (int g = 0; g < N; g++) begin
                int         d;
                logic [W-1:0] sb;
                d = div_of(g);
                if (rst) k[g] = -1;
                else if (k[g] == -1) begin
                    if (pv[g]) begin k[g] = 0; mbyte[g] = pd[g]; end
                end else begin
                    k[g]++;
                    if (k[g] > 2 * d * (W + 1)) k[g] = -1;
                end
                check("outputs{rdy,busy,done,sclk,mosi}", g,
                      {27'd0, rdy_v[g], busy_v[g], done_v[g], sclk_v[g], mosi_v[g]},
                      {27'd0, exp_out(k[g], d, lsb_of(g), mbyte[g])});

                if (rst) rise_cnt[g] = 0;
                else begin
                    if (pa[g]) begin acc_cyc[g] = cyc; rise_cnt[g] = 0; cap[g] = '0; end
                    if (sclk_v[g] && !psclk[g]) begin
                        if (rise_cnt[g] == 0) first_gap[g] = cyc - fall_cyc[g] - 1;
                        cap[g] = {cap[g][7:0], mosi_v[g]};
                        rise_cnt[g]++;
                        if (rise_cnt[g] == W + 1) begin
                            sb = '0;
                            for (int i = 0; i < W; i++) begin
                                if (lsb_of(g) != 0) sb[i] = cap[g][8-i];
                                else sb[W-1-i] = cap[g][8-i];
                            end
                            sbyte[g] = sb;
                            check("slave_byte", g, {24'd0, sb}, {24'd0, mbyte[g]});
                        end
                    end
                    if (!sclk_v[g] && psclk[g]) fall_cyc[g] = cyc;
                    if (done_v[g]) begin
                        lat[g] = cyc - acc_cyc[g];
                        done_cyc[g] = cyc;
                        done_cnt[g]++;
                    end
                end
                psclk[g] = sclk_v[g];
                pv[g]    = valid_v[g] && !rst;
                pd[g]    = data_a[g];
                pa[g]    = valid_v[g] && rdy_v[g] && !rst;
            end
        end
    end

    task automatic send(input int g, input logic [W-1:0] b);
        int n;
        n = 0;
        @(posedge clk); #1;
        while (!rdy_v[g] && n < 1000) begin @(posedge clk); #1; n++; end
        data_a[g] = b; valid_v[g] = 1'b1;
        @(posedge clk); #1;
        valid_v[g] = 1'b0;
    endtask

    task automatic wait_done(input int g, input int budget);
        int dc, n;
        dc = done_cnt[g]; n = 0;
        while (done_cnt[g] == dc && n < budget) begin @(posedge clk); n++; end
        if (done_cnt[g] == dc) begin
            checks++; errors++;
            $display("FAIL done_timeout dut%0d: no done within %0d cycles, expected one", g, budget);
        end
        #1;
    endtask

    initial begin
        int a0, n, dcnt;
        for (int g = 0; g < N; g++) data_a[g] = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int g = 0; g < N; g++)
            check("reset_state", g, {27'd0, rdy_v[g], busy_v[g], done_v[g], sclk_v[g], mosi_v[g]}, 32'b10000);
        rst = 1'b0;

        // LSB first 0xA5
        send(0, 8'hA5);
        wait_done(0, 200);
        check("lsb_a5_bits", 0, {23'd0, cap[0]}, 32'b101001010);
        check("lsb_a5_latency", 0, lat[0], 36);
        check("lsb_a5_slave", 0, {24'd0, sbyte[0]}, 32'hA5);

        // MSB first 0x3C, with a 0x55 pulse while busy that must be ignored
        send(1, 8'h3C);
        repeat (10) @(posedge clk);
        #1 data_a[1] = 8'h55; valid_v[1] = 1'b1;
        @(posedge clk);
        #1 valid_v[1] = 1'b0;
        wait_done(1, 200);
        check("msb_3c_bits", 1, {23'd0, cap[1]}, 32'b001111000);
        check("msb_3c_rises", 1, rise_cnt[1], 9);
        check("msb_3c_latency", 1, lat[1], 36);
        check("msb_3c_slave", 1, {24'd0, sbyte[1]}, 32'h3C);

        // Back-to-back: valid held high, 0x01 then 0xFF
        @(posedge clk); #1;
        data_a[1] = 8'h01; valid_v[1] = 1'b1;
        @(posedge clk); #1;
        data_a[1] = 8'hFF;
        wait_done(1, 200);
        check("b2b_first_slave", 1, {24'd0, sbyte[1]}, 32'h01);
        a0 = acc_cyc[1]; n = 0;
        while (acc_cyc[1] == a0 && n < 20) begin @(posedge clk); n++; end
        check("b2b_accept_after_done", 1, acc_cyc[1] - done_cyc[1], 2);
        wait_done(1, 200);
        valid_v[1] = 1'b0;
        check("b2b_sclk_gap", 1, first_gap[1], 3);
        check("b2b_second_slave", 1, {24'd0, sbyte[1]}, 32'hFF);
        check("b2b_second_latency", 1, lat[1], 36);

        // Reset mid-frame after the 4th sclk rise
        send(3, 8'hC3);
        n = 0;
        while (rise_cnt[3] < 4 && n < 200) begin @(negedge clk); n++; end
        check("rst_reached_4_rises", 3, rise_cnt[3], 4);
        #2 rst = 1'b1;
        #1;
        check("rst_midframe_outputs", 3, {27'd0, rdy_v[3], busy_v[3], done_v[3], sclk_v[3], mosi_v[3]}, 32'b10000);
        dcnt = done_cnt[3];
        #10 rst = 1'b0;
        repeat (120) @(posedge clk);
        check("rst_no_done", 3, done_cnt[3], dcnt);

        // Divider extremes
        send(2, 8'h81);
        wait_done(2, 100);
        check("div1_latency", 2, lat[2], 18);
        check("div1_bits", 2, {23'd0, cap[2]}, 32'b100000010);
        check("div1_slave", 2, {24'd0, sbyte[2]}, 32'h81);
        send(3, 8'h5A);
        wait_done(3, 300);
        check("div5_latency", 3, lat[3], 90);
        check("div5_slave", 3, {24'd0, sbyte[3]}, 32'h5A);

        // Random traffic on all four, reference checks every cycle
        for (int g = 0; g < N; g++) a0 = a0 + 0;
        begin
            int start [N];
            for (int g = 0; g < N; g++) start[g] = done_cnt[g];
            for (int c = 0; c < 3000; c++) begin
                @(posedge clk); #1;
                for (int g = 0; g < N; g++) begin
                    valid_v[g] = ($urandom_range(0, 3) == 0);
                    data_a[g]  = W'($urandom);
                end
            end
            valid_v = '0;
            repeat (200) @(posedge clk);
            for (int g = 0; g < N; g++)
                check("random_frames_seen", g, {31'd0, done_cnt[g] > start[g] + 5}, 32'd1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end
endmodule
